tft_pixel_out: RTL and testbench
================================

Name: tft_pixel_out

Overview:
- Display-side consumer of the TFT frame-buffer DMA word stream.
- Unpacks each 32-bit word into two RGB565 pixels and generates the TFT timing signals (pixel clock, HSYNC, VSYNC, DE).
- Drives the active-high vertical-sync indication back to the DMA so it restarts at the frame base address each frame.
- Runs entirely in the AHB clock domain and derives the pixel rate with a clock-enable divider.

Parameters:
- H_ACTIVE, 480, visible pixels per line; must be even.
- H_FP, 2, horizontal front porch, in pixels.
- H_SYNC, 41, HSYNC width, in pixels.
- H_BP, 2, horizontal back porch, in pixels.
- V_ACTIVE, 272, visible lines per frame.
- V_FP, 2, vertical front porch, in lines.
- V_SYNC, 10, VSYNC width, in lines.
- V_BP, 2, vertical back porch, in lines.
- CLK_DIV, 4, HCLK cycles per pixel; must be even and ≥2.

Ports:
- HCLK  in  1  system/AHB clock
- HRESET  in  1  asynchronous active-high reset
- ENABLE  in  1  display enable
- DATA_IN  in  32  pixel word from DMA; [15:0] is the left pixel, [31:16] the right pixel
- REQ_IN  in  1  DATA_IN valid
- ACK_OUT  out  1  word consumed in this HCLK cycle
- VSYNC_OUT  out  1  active-high vertical sync to DMA
- TFT_CLK  out  1  pixel clock
- TFT_HSYNC  out  1  active-low
- TFT_VSYNC  out  1  active-low
- TFT_DE  out  1  data enable
- TFT_RGB  out  16  RGB565 pixel
- UNDERRUN  out  1  sticky flag: pixel data missing
- UNDERRUN_CLR  in  1  clears UNDERRUN

Behaviour:
- Reset state:
  - All counters 0.
  - ACK_OUT=0, VSYNC_OUT=1, TFT_CLK=0, TFT_HSYNC=1, TFT_VSYNC=1, TFT_DE=0, TFT_RGB=0, UNDERRUN=0.
- Pixel divider:
  - div counts 0..CLK_DIV-1 while ENABLE=1.
  - tick = (div==CLK_DIV-1).
  - TFT_CLK is registered: 0 for div < CLK_DIV/2, else 1. The falling edge coincides with output updates, so the panel samples on the rising edge.
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcnt runs 0..V_TOTAL-1, defined the same way from the V_ parameters.
  - Both advance only on tick; vcnt increments when hcnt wraps. Counter width is $clog2 of the total.
- Region order, both axes: active, front porch, sync, back porch.
  - hsync when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync region follows the same rule on vcnt using the V_ parameters.
- Output register updates, all on tick and all registered:
  - TFT_HSYNC = ~hsync.
  - TFT_VSYNC = ~vsync.
  - VSYNC_OUT = vsync.
  - TFT_DE = (hcnt < H_ACTIVE && vcnt < V_ACTIVE).
- Pixel path, on an active tick:
  - Even hcnt with REQ_IN=1: ACK_OUT=1 for exactly that HCLK cycle, TFT_RGB=DATA_IN[15:0], and DATA_IN[31:16] is latched into the hold register.
  - Odd hcnt: TFT_RGB=hold; ACK_OUT stays 0.
  - Outside the active region: TFT_RGB=0.
  - Maximum of one ACK per two ticks.
- Underrun:
  - Even active tick with REQ_IN=0: no ACK, TFT_RGB=0, hold=0 (so the odd pixel is also 0), UNDERRUN set.
  - Timing continues unaffected.
  - UNDERRUN_CLR clears the flag. If a set and a clear happen in the same cycle, set wins.
- Drain:
  - While vsync is active (VSYNC_OUT=1) or ENABLE=0, ACK_OUT = REQ_IN in every HCLK cycle, independent of tick.
  - This discards burst beats still in flight after DMA disable, so the next frame starts word-aligned at the base address.
  - Constraint: V_SYNC lines must cover at least 16 beats plus DMA latency.
- ENABLE behaviour:
  - ENABLE=0: div, hcnt and vcnt are held. Outputs go to their reset values (VSYNC_OUT=1 keeps the DMA disabled), except UNDERRUN, which holds its value.
  - ENABLE rising: the next cycle starts with hcnt=0, vcnt=V_ACTIVE+V_FP (start of vsync), div=0. This gives the DMA the sync and back-porch lines to prefetch.
- Reset mid-frame returns everything to the reset state immediately (asynchronous).

Test Plan:
- Timing. Parameters H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=2, V_BP=1, CLK_DIV=2; ENABLE=1, REQ_IN=1 constant:
  - Line period is 16 HCLK.
  - TFT_HSYNC is low for 4 HCLK starting 10 HCLK after line start.
  - VSYNC_OUT is high for 32 HCLK per 96 HCLK frame.
  - TFT_DE is high for 8 HCLK on each of 2 lines.
- Unpack. Feed 0x2222_1111 then 0x4444_3333:
  - TFT_RGB sequence is 1111, 2222, 3333, 4444.
  - Exactly 2 single-cycle ACK_OUT pulses per active line, each on an even-pixel tick.
- Underrun. Drop REQ_IN for the 2nd word of a line:
  - Pixels 2 and 3 are 0x0000; UNDERRUN=1 and stays 1.
  - Pulse UNDERRUN_CLR: UNDERRUN=0 the next cycle.
  - Assert set and clear in the same cycle: UNDERRUN=1.
- Drain. During vsync, hold REQ_IN=1 for 5 cycles:
  - ACK_OUT=1 on all 5 cycles, TFT_RGB=0.
  - After vsync ends, ACK_OUT returns to pixel-tick pacing.
- Enable. Deassert ENABLE mid-line:
  - Next cycle: TFT_DE=0, VSYNC_OUT=1, and ACK_OUT follows REQ_IN.
  - Reassert ENABLE: vsync occupies the first V_SYNC lines, then active video starts after V_BP lines.
- Reset. Assert HRESET mid-active-line:
  - All outputs at reset values in the same cycle, without waiting for a clock edge.
  - After release with ENABLE=1, the first frame starts at vsync.

Source files
------------

// File: rtl/tft_pixel_out.sv
// tft_pixel_out
//   Display-side consumer of the TFT frame-buffer DMA word stream. Each 32-bit
//   word carries two RGB565 pixels (left in [15:0], right in [31:16]). The block
//   derives the pixel rate from HCLK with a clock-enable divider, generates the
//   panel timing and signals vertical sync back to the DMA.
//
// Ports
//   HCLK          system/AHB clock
//   HRESET        asynchronous active-high reset
//   ENABLE        display enable
//   DATA_IN       pixel word from the DMA
//   REQ_IN        DATA_IN valid
//   ACK_OUT       word consumed in this HCLK cycle
//   VSYNC_OUT     active-high vertical sync to the DMA
//   TFT_CLK       pixel clock (falls when outputs update)
//   TFT_HSYNC     horizontal sync, active-low
//   TFT_VSYNC     vertical sync, active-low
//   TFT_DE        data enable
//   TFT_RGB       RGB565 pixel
//   UNDERRUN      sticky flag: pixel data was missing
//   UNDERRUN_CLR  clears UNDERRUN (a simultaneous set wins)
module tft_pixel_out #(
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter int CLK_DIV  = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        ENABLE,
   input  logic [31:0] DATA_IN,
   input  logic        REQ_IN,
   output logic        ACK_OUT,
   output logic        VSYNC_OUT,
   output logic        TFT_CLK,
   output logic        TFT_HSYNC,
   output logic        TFT_VSYNC,
   output logic        TFT_DE,
   output logic [15:0] TFT_RGB,
   output logic        UNDERRUN,
   input  logic        UNDERRUN_CLR
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);

   logic [DW-1:0] div;
   logic [DW-1:0] div_nxt;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic          en_d;      // ENABLE as seen last cycle; low means "restart timing"
   logic [15:0]   hold;      // right-hand pixel of the current word
   logic          tick;
   logic          active;
   logic          even_act;
   logic          hsync;
   logic          vsync;
   logic          pix_take;
   logic          underrun_set;

   assign tick         = ENABLE & en_d & (div == DIV_LAST);
   assign div_nxt      = tick ? '0 : div + 1'b1;
   assign active       = (hcnt < H_ACT_END) & (vcnt < V_ACT_END);
   assign even_act     = tick & active & ~hcnt[0];
   assign hsync        = (hcnt >= H_SYNC_BEG) & (hcnt < H_SYNC_END);
   assign vsync        = (vcnt >= V_SYNC_BEG) & (vcnt < V_SYNC_END);
   assign pix_take     = even_act & REQ_IN;
   assign underrun_set = even_act & ~REQ_IN;

   // While vsync is signalled or the display is off, every offered beat is
   // swallowed so the DMA's in-flight burst drains and the next frame starts
   // word-aligned at the base address.
   assign ACK_OUT = ~HRESET & ((~ENABLE | VSYNC_OUT) ? REQ_IN : pix_take);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         en_d      <= 1'b0;
         div       <= '0;
         hcnt      <= '0;
         vcnt      <= '0;
         TFT_CLK   <= 1'b0;
         TFT_HSYNC <= 1'b1;
         TFT_VSYNC <= 1'b1;
         VSYNC_OUT <= 1'b1;
         TFT_DE    <= 1'b0;
         TFT_RGB   <= '0;
      end else if (!ENABLE) begin
         // Counters freeze; outputs fall back to idle (VSYNC_OUT high keeps the DMA parked).
         en_d      <= 1'b0;
         TFT_CLK   <= 1'b0;
         TFT_HSYNC <= 1'b1;
         TFT_VSYNC <= 1'b1;
         VSYNC_OUT <= 1'b1;
         TFT_DE    <= 1'b0;
         TFT_RGB   <= '0;
      end else if (!en_d) begin
         // Restart at the top of vsync so the DMA gets the sync and back-porch
         // lines to prefetch before the first visible pixel.
         en_d    <= 1'b1;
         div     <= '0;
         hcnt    <= '0;
         vcnt    <= V_SYNC_BEG;
         TFT_CLK <= 1'b0;
      end else begin
         div     <= div_nxt;
         TFT_CLK <= (div_nxt >= DIV_HALF);
         if (tick) begin
            if (hcnt == H_LAST) begin
               hcnt <= '0;
               vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
            TFT_HSYNC <= ~hsync;
            TFT_VSYNC <= ~vsync;
            VSYNC_OUT <= vsync;
            TFT_DE    <= active;
            if (!active)
               TFT_RGB <= '0;
            else if (!hcnt[0])
               TFT_RGB <= REQ_IN ? DATA_IN[15:0] : 16'h0000;
            else
               TFT_RGB <= hold;
         end
      end
   end

   // A missing word blanks both of its pixels.
   always_ff @(posedge HCLK) begin
      if (even_act)
         hold <= REQ_IN ? DATA_IN[31:16] : 16'h0000;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         UNDERRUN <= 1'b0;
      else if (underrun_set)
         UNDERRUN <= 1'b1;
      else if (UNDERRUN_CLR)
         UNDERRUN <= 1'b0;
   end

endmodule

// File: tb/tb_tft_pixel_out.sv
module tb_tft_pixel_out;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 2, VF = 1, VS = 2, VB = 1;
   localparam int CD = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int START = (VA + VF) * HT;   // first pixel after enable: top of vsync

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        ENABLE;
   logic [31:0] DATA_IN;
   logic        REQ_IN;
   logic        ACK_OUT;
   logic        VSYNC_OUT;
   logic        TFT_CLK;
   logic        TFT_HSYNC;
   logic        TFT_VSYNC;
   logic        TFT_DE;
   logic [15:0] TFT_RGB;
   logic        UNDERRUN;
   logic        UNDERRUN_CLR;

   tft_pixel_out #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(CD)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
      .REQ_IN(REQ_IN), .ACK_OUT(ACK_OUT), .VSYNC_OUT(VSYNC_OUT),
      .TFT_CLK(TFT_CLK), .TFT_HSYNC(TFT_HSYNC), .TFT_VSYNC(TFT_VSYNC),
      .TFT_DE(TFT_DE), .TFT_RGB(TFT_RGB), .UNDERRUN(UNDERRUN),
      .UNDERRUN_CLR(UNDERRUN_CLR)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int errors = 0;

   // Reference model: time is counted in HCLK edges since the restart edge;
   // pixel position is derived arithmetically from that count.
   bit          en_prev;
   int          n;
   logic        e_clk, e_hs, e_vs, e_vso, e_de, e_und;
   logic [15:0] e_rgb, e_hold;

   function automatic void pix(input int k, output int h, output int v);
      int p;
      p = START + k;
      h = p % HT;
      v = (p / HT) % VT;
   endfunction

   function automatic bit next_even_active();
      int h, v;
      if (!(en_prev && ENABLE && ((n + 1) % CD == 0))) return 1'b0;
      pix((n + 1) / CD - 1, h, v);
      return (h < HA) && (v < VA) && (h % 2 == 0);
   endfunction

   function automatic logic exp_ack();
      if (HRESET) return 1'b0;
      if (!ENABLE || e_vso) return REQ_IN;
      return next_even_active() && REQ_IN;
   endfunction

   function automatic void model_reset();
      en_prev = 0; n = 0;
      e_clk = 0; e_hs = 1; e_vs = 1; e_vso = 1; e_de = 0; e_rgb = 0; e_und = 0;
   endfunction

   function automatic void model_edge();
      int h, v;
      bit set, act;
      set = 0;
      if (!ENABLE) begin
         en_prev = 0; n = 0;
         e_clk = 0; e_hs = 1; e_vs = 1; e_vso = 1; e_de = 0; e_rgb = 0;
      end else if (!en_prev) begin
         en_prev = 1; n = 0; e_clk = 0;
      end else begin
         n++;
         e_clk = ((n % CD) >= CD / 2);
         if (n % CD == 0) begin
            pix(n / CD - 1, h, v);
            e_hs  = !(h >= HA + HF && h < HA + HF + HS);
            e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            e_vso = !e_vs;
            act   = (h < HA) && (v < VA);
            e_de  = act;
            if (!act) e_rgb = 16'h0;
            else if (h % 2 == 0) begin
               if (REQ_IN) begin e_rgb = DATA_IN[15:0]; e_hold = DATA_IN[31:16]; end
               else begin e_rgb = 16'h0; e_hold = 16'h0; set = 1; end
            end else e_rgb = e_hold;
         end
      end
      if (set) e_und = 1;
      else if (UNDERRUN_CLR) e_und = 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_outs();
      chk("tft_clk",   TFT_CLK,   e_clk);
      chk("tft_hsync", TFT_HSYNC, e_hs);
      chk("tft_vsync", TFT_VSYNC, e_vs);
      chk("vsync_out", VSYNC_OUT, e_vso);
      chk("tft_de",    TFT_DE,    e_de);
      chk("tft_rgb",   TFT_RGB,   e_rgb);
      chk("underrun",  UNDERRUN,  e_und);
   endtask

   // Inputs are set at the falling edge; ACK is checked before the rising edge,
   // registered outputs after it.
   task automatic cyc();
      #1 chk("ack_out", ACK_OUT, exp_ack());
      @(posedge HCLK);
      model_edge();
      @(negedge HCLK);
      chk_outs();
   endtask

   initial begin
      bit found;
      HRESET = 1'b1; ENABLE = 1'b0; REQ_IN = 1'b0; DATA_IN = '0; UNDERRUN_CLR = 1'b0;
      e_hold = '0;
      model_reset();
      #2;
      chk_outs();
      chk("ack_rst", ACK_OUT, 1'b0);

      // Steady stream, two frames plus start-up.
      @(negedge HCLK);
      HRESET = 1'b0; ENABLE = 1'b1;
      repeat (2 * HT * VT * CD + 4) begin
         REQ_IN = 1'b1; DATA_IN = $urandom; cyc();
      end

      // Gappy stream with random clears.
      repeat (4 * HT * VT * CD) begin
         REQ_IN = ($urandom_range(3) != 0); DATA_IN = $urandom;
         UNDERRUN_CLR = ($urandom_range(4) == 0);
         cyc();
      end
      UNDERRUN_CLR = 1'b0;

      // Underrun and clear on the same cycle: set wins.
      found = 0;
      for (int i = 0; i < 4 * HT * VT * CD && !found; i++) begin
         if (next_even_active()) begin
            REQ_IN = 1'b0; UNDERRUN_CLR = 1'b1; DATA_IN = $urandom;
            cyc();
            chk("und_set_wins", UNDERRUN, 1'b1);
            REQ_IN = 1'b1; UNDERRUN_CLR = 1'b1; cyc();
            chk("und_cleared", UNDERRUN, 1'b0);
            UNDERRUN_CLR = 1'b0;
            found = 1;
         end else begin
            REQ_IN = 1'b1; DATA_IN = $urandom; cyc();
         end
      end
      chk("found_even_tick", found, 1'b1);

      // Disable in the middle of an active line, then restart.
      found = 0;
      for (int i = 0; i < 4 * HT * VT * CD && !found; i++) begin
         REQ_IN = 1'b1; DATA_IN = $urandom; cyc();
         if (e_de) found = 1;
      end
      chk("found_active_a", found, 1'b1);
      REQ_IN = 1'b1; cyc();
      ENABLE = 1'b0;
      repeat (6) begin REQ_IN = $urandom_range(1); DATA_IN = $urandom; cyc(); end
      chk("dis_de", TFT_DE, 1'b0);
      chk("dis_vso", VSYNC_OUT, 1'b1);
      ENABLE = 1'b1;
      repeat (2 * HT * VT * CD) begin
         REQ_IN = ($urandom_range(7) != 0); DATA_IN = $urandom; cyc();
      end

      // Asynchronous reset mid active line.
      found = 0;
      for (int i = 0; i < 4 * HT * VT * CD && !found; i++) begin
         REQ_IN = 1'b1; DATA_IN = $urandom; cyc();
         if (e_de) found = 1;
      end
      chk("found_active_b", found, 1'b1);
      #2 HRESET = 1'b1;
      model_reset();
      #1;
      chk_outs();
      chk("ack_async_rst", ACK_OUT, 1'b0);
      @(negedge HCLK);
      HRESET = 1'b0;
      repeat (HT * VT * CD + 8) begin
         REQ_IN = 1'b1; DATA_IN = $urandom; cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
